// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared widths and types for the round-robin mux feeder
package rr_mux_pkg;
  localparam int W     = 4;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  typedef logic [W-1:0]     word_t;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/rr_pick_4.sv
// rtl/rr_pick_4.sv - rotating priority search over four requests
module rr_pick_4
  import rr_mux_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last_grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any_req
);

  // Search starts just after the previous winner; the 2-bit add wraps 3 -> 0.
  always_comb begin
    sel_t cand;
    logic found;
    cand      = '0;
    found     = 1'b0;
    grant_idx = last_grant;
    for (int k = 1; k <= N; k++) begin
      cand = last_grant + SEL_W'(k);
      if (!found && req[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/rr_mux_feeder_4.sv
// rtl/rr_mux_feeder_4.sv - four one-word channel buffers feeding a registered
// output slot by round-robin arbitration
module rr_mux_feeder_4
  import rr_mux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready
);

  logic [N-1:0] buf_full;
  word_t        buf_data [N];
  sel_t         last_grant;
  sel_t         grant_idx;
  logic         any_req;
  logic         slot_free;
  logic         take;

  // Ready depends on buffer state only, so a drained buffer refills one cycle later.
  assign in_ready  = ~buf_full;
  assign slot_free = ~out_valid | out_ready;
  assign take      = slot_free & any_req;

  rr_pick_4 u_pick (
    .req        (buf_full),
    .last_grant (last_grant),
    .grant_idx  (grant_idx),
    .any_req    (any_req)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full   <= '0;
      for (int i = 0; i < N; i++) buf_data[i] <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= SEL_W'(N - 1);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          buf_full[i] <= 1'b1;
          buf_data[i] <= in_data[i*W +: W];
        end
      end
      // A granted buffer is full, so it never collides with a capture above.
      if (take) begin
        buf_full[grant_idx] <= 1'b0;
        out_data            <= buf_data[grant_idx];
        out_sel             <= grant_idx;
        out_valid           <= 1'b1;
        last_grant          <= grant_idx;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rr_mux_feeder_4.md
Name: rr_mux_feeder_4

Overview:
- Upstream stage of the 4:1 4-bit mux datapath.
- Accepts four independent valid/ready channels of 4-bit data and buffers one word per channel.
- Each cycle the output slot is free, it picks one buffered word by round-robin arbitration.
- Presents the chosen word on a registered valid/ready output, together with the 2-bit channel index in the mux select encoding (0..3 selects d0..d3).

Parameters:
- W, 4, data width per channel.
- N, 4, channel count; fixed at 4; index width 2.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  4  per-channel valid; bit i is channel i.
- in_data  in  4*W  channel i data at bits [i*W +: W].
- in_ready  out  4  per-channel ready; equals ~buf_full[i].
- out_valid  out  1  output word valid.
- out_data  out  W  selected word.
- out_sel  out  2  channel index of out_data, mux select encoding.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset, asynchronous and active-high:
  - buf_full = 0, so in_ready = 4'b1111.
  - out_valid = 0, out_data = 0, out_sel = 0.
  - Round-robin pointer last_grant = 3, so channel 0 has first priority.
- Input capture:
  - Channel i handshakes when in_valid[i] & in_ready[i].
  - The word goes into buf_data[i] and buf_full[i] sets on that edge.
  - in_ready[i] is a registered-state function only, with no combinational path from out_ready.
  - A buffer drained in a cycle cannot be refilled in that same cycle. The refill handshake occurs the cycle after drain, since in_ready rises then.
- Output slot free condition: slot_free = ~out_valid | out_ready.
- Arbitration, when slot_free and any buf_full:
  - Search order is last_grant+1, +2, +3, +0 (mod 4).
  - The first full buffer g wins.
  - On the clock edge: out_data <= buf_data[g], out_sel <= g, out_valid <= 1, buf_full[g] <= 0, last_grant <= g.
- Hold rule: if slot_free and no buffer is full, out_valid <= 0. out_data and out_sel hold their last values.
- Stall rule: if out_valid & ~out_ready, out_valid, out_data, out_sel, last_grant and all buffers hold.
  - out_data and out_sel must stay stable while out_valid is high and unaccepted.
- Latency: input handshake at edge N; earliest out_valid after edge N+1 (2-cycle minimum).
- Throughput:
  - Aggregate: one word per cycle when out_ready = 1 and at least one buffer is full.
  - Per channel: at most one word every 2 cycles.
- Fairness:
  - With all four channels continuously full and out_ready = 1, grant order is 0,1,2,3,0,…
  - No channel waits more than 3 grants.
- Boundary cases:
  - Empty buffers: output drains to invalid after the final accept.
  - All full and out stalled: in_ready = 0000.
  - Pointer wraps 3 -> 0 by 2-bit overflow.
  - Simultaneous input handshake on channel i and a grant of a different channel j in one cycle is legal and independent.
  - Reset asserted mid-transfer discards all buffered words and any pending output word immediately, without waiting for a clock edge.
- No data transformation: out_data equals the captured word bit-exactly.

Decomposition:
- Shared package rr_mux_pkg:
  - localparam W = 4, N = 4, SEL_W = 2.
  - typedef logic [W-1:0] word_t.
  - typedef logic [SEL_W-1:0] sel_t.
- Sub-module rr_pick_4 (combinational):
  - Inputs: req[3:0], last_grant sel_t.
  - Outputs: grant_idx sel_t, any_req.
  - Implements the rotate/priority search. Instantiated once.
- Top module holds the per-channel buffers, the output register and last_grant.

Test Plan:
- Reset check: assert rst mid-run with all buffers full -> in_ready = 1111, out_valid = 0, out_data = 0, out_sel = 0 with no clock edge needed.
- Single channel: ch2 sends 4'hA at edge N, out_ready = 1 -> out_valid = 1, out_data = A, out_sel = 2 after edge N+1; out_valid = 0 the following cycle.
- Round-robin with all full:
  - Load ch0..ch3 with 1, 2, 3, 4 in one cycle, out_ready = 1.
  - Required: outputs (data, sel) = (1,0), (2,1), (3,2), (4,3) on consecutive cycles.
  - Then ch1 and ch3 reload 5 and 6 -> order (5,1), (6,3).
- Backpressure:
  - Hold out_ready = 0 for 5 cycles with ch0 = 7 and ch1 = 8 buffered.
  - Required: out_data = 7, out_sel = 0 stable all 5 cycles; in_ready[1] = 0.
  - On release: 7 then 8 on consecutive cycles.
- Pointer wrap and fairness:
  - Last grant 3, ch3 and ch0 both full -> ch0 granted first, then ch3.
  - Continuous traffic on all 4 channels for 1000 cycles with random out_ready -> no channel skipped more than 3 grants; scoreboard shows zero loss and zero reordering per channel.
